op_sequencer: RTL and testbench
===============================

# op_sequencer

Command sequencer that sits directly upstream of the matrix controller and produces its `operation` and `in_data` inputs. It buffers host commands in a small FIFO and, for serial page writes (opcode 2), streams data words through a valid/ready port, one word per cycle. For multiplies (opcode 1), it holds the op word for the fixed shift duration the controller needs, then inserts an idle gap so the controller sees a fresh rising edge of opcode 1 on the next multiply.

## Interface
Parameters:
- `DEPTH`, 8: command FIFO entries (power of two, ≥2).
- `MULT_HOLD`, 80: cycles opcode 1 is held (64 shift cycles plus 16 multiplier drain).
- `GAP_CYCLES`, 1: idle cycles (operation = 0) after each multiply; must be ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global enable; low freezes all state.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  FIFO can accept (not full and `enable`).
- `cmd_data`  in  32  command word: [3:0] opcode, [19:4] fields passed to the controller, [31:20] write length minus 1 (opcode 2 only).
- `dat_valid`  in  1  write data valid.
- `dat_ready`  out  1  sequencer consumes a data word this cycle.
- `dat_data`  in  32  write data word.
- `operation`  out  32  to controller; registered.
- `in_data`  out  32  to controller; registered.
- `busy`  out  1  FIFO non-empty or state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a write or multiply command completes.
- `err`  out  1  sticky flag: an opcode in 3..15 was popped.

## Operation
- Reset (`reset` = 0, asynchronous): FIFO empty, state IDLE, counters 0. `operation`, `in_data`, `done`, `err` and `busy` are all 0.
- FIFO push on `cmd_valid && cmd_ready`. Pop happens only in IDLE.
- States: IDLE, WRITE, MULT, GAP.
- **IDLE**, FIFO non-empty: pop the head into `cur`.
  - Opcode 1 → MULT, with `cnt` = MULT_HOLD−1.
  - Opcode 2 → WRITE, with `rem` = `cur[31:20]`+1 (range 1..4096).
  - Opcode 0 → stay in IDLE (discarded).
  - Opcode 3..15 → set `err` and stay in IDLE (discarded).
  - `operation` is 0 in IDLE.
- **MULT**: `operation` = {12'b0, `cur[19:0]`} on every cycle in MULT.
  - `cnt` decrements each cycle.
  - At `cnt` = 0: pulse `done`, go to GAP with `cnt` = GAP_CYCLES−1.
- **GAP**: `operation` = 0. At `cnt` = 0 go to IDLE. No pop occurs in GAP.
- **WRITE**: `dat_ready` = `enable` && state = WRITE. It is combinational from state.
  - On `dat_valid && dat_ready`: register `operation` = {12'b0, `cur[19:0]`} and `in_data` = `dat_data`, and decrement `rem`.
  - Without a handshake: register `operation` = 0 (bubble) and hold `in_data`.
  - On the handshake with `rem` = 1: pulse `done` and go to IDLE. No gap is inserted after a write.
- `enable` low:
  - `cmd_ready` = 0 and `dat_ready` = 0.
  - FIFO, state, counters and all outputs hold their values; `done` holds.
- Simultaneous push and pop in IDLE are allowed; the occupancy count stays consistent.
- FIFO full: `cmd_ready` = 0 and the host must hold the command.
- FIFO empty in IDLE: remain in IDLE with `operation` = 0.

## Timing
- A command accepted at edge k into an empty FIFO while in IDLE is popped at edge k+1.
- The first `operation` word appears after edge k+2:
  - For MULT, immediately.
  - For WRITE, with the first data handshake at edge k+2.
- A WRITE data word handshaked at edge j appears on `operation`/`in_data` after edge j. The controller samples it at edge j+1.
- MULT drives opcode 1 for exactly MULT_HOLD consecutive cycles, followed by exactly GAP_CYCLES cycles of 0.
- The next pop happens at the first IDLE edge after GAP, so back-to-back multiplies are spaced MULT_HOLD+GAP_CYCLES+1 cycles apart.
- `done` is high for the cycle following the completing edge.
- Reset asserted mid-command aborts it immediately. All outputs go to 0 without waiting for a clock edge, and the FIFO contents are lost.

## Test plan
- Reset, then push one multiply (`cmd_data` = 0x0000_1201) → `operation` = 0x0000_1201 for exactly 80 cycles, then 0 for 1 cycle; `done` pulses once; `busy` then falls.
- Push a write (`cmd_data` = 0x0030_0F82, 4 words) with `dat_valid` held high, data 0xA0..0xA3 → `operation` = 0x0000_0F82 for 4 consecutive cycles, `in_data` = 0xA0, 0xA1, 0xA2, 0xA3; `done` pulses after the last word.
- Same write with `dat_valid` toggling 1,0,1,0,... → `operation` alternates 0x0F82/0 and `in_data` holds during bubbles; exactly 4 handshakes occur.
- Push 9 commands while a multiply is running (DEPTH = 8) → `cmd_ready` falls after 8 entries; all commands execute in push order; an opcode-5 command sets `err` and is skipped.
- Drop `enable` for 10 cycles mid-MULT → the `operation` hold count excludes the frozen cycles (total of 80 enabled cycles); `dat_ready` and `cmd_ready` are 0 during the freeze.
- Assert `reset` low asynchronously mid-WRITE → `operation`, `in_data` and `busy` go to 0 before the next edge; after release, the sequencer is in IDLE with an empty FIFO.

Source files
------------

// File: rtl/op_sequencer.sv
// op_sequencer: command FIFO feeding the matrix controller, with multiply hold/gap timing and streamed page writes.
module op_sequencer #(
    parameter int DEPTH      = 8,
    parameter int MULT_HOLD  = 80,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    input  logic        dat_valid,
    output logic        dat_ready,
    input  logic [31:0] dat_data,
    output logic [31:0] operation,
    output logic [31:0] in_data,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = MULT_HOLD > GAP_CYCLES ? MULT_HOLD : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [1:0] {IDLE, WRITE, MULT, GAP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   head, word, op_nxt, in_nxt;
    logic [19:0]   cur;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [12:0]   rem, rem_nxt;
    logic          done_nxt, push, pop, hs;

    assign head      = mem[rd_ptr];
    assign word      = {12'b0, cur};
    assign cmd_ready = enable && count != (AW+1)'(DEPTH);
    assign dat_ready = enable && state == WRITE;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = enable && state == IDLE && count != '0;
    assign hs        = dat_valid && dat_ready;
    assign busy      = count != '0 || state != IDLE;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= cmd_data;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            cur       <= '0;
            operation <= '0;
            in_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else if (enable) begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rem       <= rem_nxt;
            operation <= op_nxt;
            in_data   <= in_nxt;
            done      <= done_nxt;
            if (pop) cur <= head[19:0];
            if (pop && head[3:0] > 4'd2) err <= 1'b1;
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
        end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rem_nxt   = rem;
        case (state)
            IDLE: if (pop) begin
                state_nxt = head[3:0] == 4'd1 ? MULT : head[3:0] == 4'd2 ? WRITE : IDLE;
                cnt_nxt   = CW'(MULT_HOLD - 1);
                rem_nxt   = {1'b0, head[31:20]} + 13'd1;
            end
            MULT: begin
                state_nxt = cnt == '0 ? GAP : MULT;
                cnt_nxt   = cnt == '0 ? CW'(GAP_CYCLES - 1) : cnt - CW'(1);
            end
            GAP: begin
                state_nxt = cnt == '0 ? IDLE : GAP;
                cnt_nxt   = cnt == '0 ? cnt : cnt - CW'(1);
            end
            WRITE: if (hs) begin
                state_nxt = rem == 13'd1 ? IDLE : WRITE;
                rem_nxt   = rem - 13'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered; a write cycle without a handshake emits a zero bubble.
    always_comb begin
        op_nxt   = (state == MULT || hs) ? word : '0;
        in_nxt   = hs ? dat_data : in_data;
        done_nxt = (state == MULT && cnt == '0) || (hs && rem == 13'd1);
    end
endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: directed checks of multiply hold/gap, write streaming, FIFO fill order, enable freeze and async reset.
module tb_op_sequencer;
    logic        clk = 0, reset = 0, enable = 1, cmd_valid = 0, dat_valid = 0;
    logic [31:0] cmd_data = 0, dat_data = 0;
    logic        cmd_ready, dat_ready, busy, done, err;
    logic [31:0] operation, in_data;
    int          errors = 0, checks = 0;

    logic        mon = 0;
    logic [31:0] seq [$];
    logic [31:0] prev_op = 0;
    int          dcnt = 0;

    logic [31:0] cmds [9] = '{32'h0000_0101, 32'h0000_0005, 32'h0000_0202, 32'h0000_0301, 32'h0000_0000,
                              32'h0010_0402, 32'h0000_0501, 32'h0000_0601, 32'h0000_0701};
    logic [31:0] exp_seq [8] = '{32'h1201, 32'h0101, 32'h0202, 32'h0301, 32'h0402, 32'h0501, 32'h0601, 32'h0701};

    op_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
        .operation(operation), .in_data(in_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (mon) begin
            if (operation != 0 && operation != prev_op) seq.push_back(operation);
            prev_op = operation;
            if (done) dcnt++;
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        int first, last, hi, dn, dn_at, hsn;
        logic acc;
        #1;
        chk("rst_op", operation, 0);
        chk("rst_in", in_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_dat_ready", dat_ready, 0);
        #11 reset = 1;
        step;

        // single multiply
        cmd_valid = 1; cmd_data = 32'h0000_1201;
        step;
        cmd_valid = 0;
        chk("mult_busy", busy, 1);
        first = -1; last = -1; hi = 0; dn = 0; dn_at = -1;
        for (int i = 1; i <= 90; i++) begin
            step;
            if (operation == 32'h1201) begin
                hi++;
                if (first < 0) first = i;
                last = i;
            end
            if (done) begin dn++; dn_at = i; end
        end
        chk("mult_hold", hi, 80);
        chk("mult_first", first, 2);
        chk("mult_last", last, 81);
        chk("mult_done_cnt", dn, 1);
        chk("mult_done_at", dn_at, 81);
        chk("mult_busy_end", busy, 0);
        chk("mult_op_end", operation, 0);

        // write, data always valid
        dat_valid = 1; dat_data = 32'hA0;
        cmd_valid = 1; cmd_data = 32'h0030_0F82;
        step;
        cmd_valid = 0;
        step;
        chk("wr_ready", dat_ready, 1);
        chk("wr_op_pre", operation, 0);
        for (int i = 0; i < 4; i++) begin
            step;
            chk("wr_op", operation, 32'h0F82);
            chk("wr_in", in_data, 32'hA0 + i);
            chk("wr_done", done, i == 3);
            dat_data = 32'hA1 + i;
        end
        dat_valid = 0;
        chk("wr_ready_end", dat_ready, 0);
        step;
        chk("wr_op_end", operation, 0);
        chk("wr_in_end", in_data, 32'hA3);
        chk("wr_done_end", done, 0);

        // write, data valid toggling
        dat_data = 32'hB0;
        cmd_valid = 1; cmd_data = 32'h0030_0F82;
        step;
        cmd_valid = 0;
        step;
        hsn = 0;
        for (int i = 0; i < 8; i++) begin
            dat_valid = (i % 2 == 0);
            dat_data = 32'hB0 + hsn;
            step;
            if (i % 2 == 0) begin
                chk("tog_op", operation, 32'h0F82);
                chk("tog_in", in_data, 32'hB0 + hsn);
                hsn++;
            end else begin
                chk("tog_bubble", operation, 0);
                chk("tog_hold", in_data, 32'hB0 + hsn - 1);
            end
            chk("tog_done", done, i == 6);
        end
        dat_valid = 0;
        chk("tog_ready_end", dat_ready, 0);
        chk("tog_busy_end", busy, 0);

        // fill FIFO behind a running multiply
        chk("fill_err_pre", err, 0);
        dat_valid = 1; dat_data = 32'hC0;
        cmd_valid = 1; cmd_data = 32'h0000_1201;
        step;
        mon = 1;
        cmd_valid = 0;
        step;
        for (int i = 0; i < 9; i++) begin
            cmd_valid = 1; cmd_data = cmds[i];
            chk(i < 8 ? "fill_ready" : "full_ready", cmd_ready, i < 8);
            acc = 0;
            for (int t = 0; t < 300 && !acc; t++) begin
                acc = cmd_ready;
                step;
            end
            chk("push_timeout", acc, 1);
        end
        cmd_valid = 0;
        for (int t = 0; t < 3000 && busy; t++) step;
        chk("drain_busy", busy, 0);
        step;
        mon = 0;
        chk("seq_len", seq.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("seq_op", i < seq.size() ? seq[i] : 32'hDEAD_BEEF, exp_seq[i]);
        chk("seq_done_cnt", dcnt, 8);
        chk("seq_err", err, 1);
        dat_valid = 0;

        // freeze enable mid-multiply
        cmd_valid = 1; cmd_data = 32'h0000_0901;
        step;
        cmd_valid = 0;
        step;
        hi = 0; dn = 0;
        for (int i = 0; i < 100; i++) begin
            enable = !(i >= 30 && i < 40);
            step;
            if (enable) begin
                if (operation == 32'h0901) hi++;
                if (done) dn++;
            end else begin
                chk("frz_cmd_ready", cmd_ready, 0);
                chk("frz_dat_ready", dat_ready, 0);
                chk("frz_op", operation, 32'h0901);
            end
        end
        enable = 1;
        chk("frz_hold", hi, 80);
        chk("frz_done_cnt", dn, 1);
        chk("frz_busy_end", busy, 0);

        // async reset mid-write
        dat_valid = 1; dat_data = 32'hD0;
        cmd_valid = 1; cmd_data = 32'h0030_0F82;
        step;
        cmd_data = 32'h0000_0A01;
        step;
        cmd_valid = 0;
        step;
        step;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_op", operation, 32'h0F82);
        chk("pre_rst_in", in_data, 32'hD0);
        #2 reset = 0;
        #1;
        chk("arst_op", operation, 0);
        chk("arst_in", in_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        #3 reset = 1;
        step;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_op", operation, 0);
        step;
        chk("post_rst_busy2", busy, 0);
        chk("post_rst_op2", operation, 0);
        chk("post_rst_err", err, 0);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
